// File: rtl/dm_responder.sv
// Data-memory responder: posted one-entry write buffer with read bypass, 1-cycle registered read data.
// Latency: read data valid the cycle after the request; writes land in the array one cycle after capture.
// Backpressure: none, one request per cycle sustained. Optional DM_STATS_EN adds saturating counters.
module dm_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_c_en,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  output logic        dm_oob_err
`ifdef DM_STATS_EN
  ,
  output logic [31:0] dm_rd_cnt,
  output logic [31:0] dm_wr_cnt,
  output logic [31:0] dm_byp_cnt
`endif
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  logic [31:0]   mem [DEPTH];

  logic          wb_valid;
  logic [AW-1:0] wb_idx;
  logic [31:0]   wb_data;
  logic [31:0]   wb_mask;

  logic          req;
  logic          rd;
  logic          wr;
  logic          oob;
  logic [AW-1:0] idx;
  logic          hit;
  logic [31:0]   arr_word;
  logic [31:0]   byp_word;

  assign req      = !DM_c_en;
  assign rd       = req && DM_r_en;
  assign wr       = req && !DM_r_en;
  assign oob      = req && ({1'b0, DM_addr} >= ADDR_LIMIT);
  assign idx      = DM_addr[AW+1:2];
  assign hit      = wb_valid && (wb_idx == idx);
  assign arr_word = mem[idx];
  // The array still holds the pre-drain value this cycle, so overlay the pending write.
  assign byp_word = (arr_word & ~wb_mask) | (wb_data & wb_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_idx     <= '0;
      wb_data    <= '0;
      wb_mask    <= '0;
      DM_rd_data <= '0;
      dm_oob_err <= 1'b0;
    end else begin
      if (wr && !oob) begin
        wb_valid <= 1'b1;
        wb_idx   <= idx;
        wb_data  <= DM_w_data;
        wb_mask  <= ~DM_w_en;
      end else begin
        wb_valid <= 1'b0;
      end

      if (rd) begin
        if (oob)      DM_rd_data <= '0;
        else if (hit) DM_rd_data <= byp_word;
        else          DM_rd_data <= arr_word;
      end

      if (req && oob) dm_oob_err <= 1'b1;
    end
  end

  // Array is not reset; a drain coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wb_valid) begin
      mem[wb_idx] <= (mem[wb_idx] & ~wb_mask) | (wb_data & wb_mask);
    end
  end

`ifdef DM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_rd_cnt  <= '0;
      dm_wr_cnt  <= '0;
      dm_byp_cnt <= '0;
    end else begin
      if (rd && !oob && (dm_rd_cnt != '1))        dm_rd_cnt  <= dm_rd_cnt + 32'd1;
      if (wr && !oob && (dm_wr_cnt != '1))        dm_wr_cnt  <= dm_wr_cnt + 32'd1;
      if (rd && !oob && hit && (dm_byp_cnt != '1)) dm_byp_cnt <= dm_byp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus randomized traffic against a word-level memory model.
module tb_dm_responder;

  localparam int DEPTH = 1024;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic        DM_c_en;
  logic        DM_r_en;
  logic [31:0] DM_w_en;
  logic [31:0] DM_addr;
  logic [31:0] DM_w_data;
  logic [31:0] DM_rd_data;
  logic        dm_oob_err;
`ifdef DM_STATS_EN
  logic [31:0] dm_rd_cnt;
  logic [31:0] dm_wr_cnt;
  logic [31:0] dm_byp_cnt;
`endif

  dm_responder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .DM_c_en    (DM_c_en),
    .DM_r_en    (DM_r_en),
    .DM_w_en    (DM_w_en),
    .DM_addr    (DM_addr),
    .DM_w_data  (DM_w_data),
    .DM_rd_data (DM_rd_data),
    .dm_oob_err (dm_oob_err)
`ifdef DM_STATS_EN
    ,
    .dm_rd_cnt  (dm_rd_cnt),
    .dm_wr_cnt  (dm_wr_cnt),
    .dm_byp_cnt (dm_byp_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: writes take effect immediately as seen by later reads; a reset
  // right after an accepted write restores that word's previous contents.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_rd;
  logic        exp_err;
  bit          last_wr;
  int          last_idx;
  logic [31:0] last_old;
  longint      m_rd_cnt, m_wr_cnt, m_byp_cnt;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_cycle(input logic r, input logic c_en, input logic r_en,
                             input logic [31:0] w_en, input logic [31:0] addr, input logic [31:0] wdata);
    int i;
    bit in_range;
    i = int'(addr[11:2]);
    in_range = (addr < LIMIT);
    if (r) begin
      if (last_wr) m_mem[last_idx] = last_old;
      last_wr = 0;
      exp_rd = '0;
      exp_err = 1'b0;
      m_rd_cnt = 0; m_wr_cnt = 0; m_byp_cnt = 0;
    end else begin
      bit hit_prev;
      hit_prev = last_wr && (last_idx == i);
      last_wr = 0;
      if (!c_en) begin
        if (!in_range) exp_err = 1'b1;
        if (r_en) begin
          exp_rd = in_range ? m_mem[i] : 32'h0;
          if (in_range) begin
            m_rd_cnt++;
            if (hit_prev) m_byp_cnt++;
          end
        end else if (in_range) begin
          last_old = m_mem[i];
          m_mem[i] = (m_mem[i] & w_en) | (wdata & ~w_en);
          last_wr  = 1;
          last_idx = i;
          m_wr_cnt++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c_en, input logic r_en,
                      input logic [31:0] w_en, input logic [31:0] addr, input logic [31:0] wdata);
    rst = r; DM_c_en = c_en; DM_r_en = r_en; DM_w_en = w_en; DM_addr = addr; DM_w_data = wdata;
    @(posedge clk);
    model_cycle(r, c_en, r_en, w_en, addr, wdata);
    #1;
  endtask

  task automatic wr_op(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] w_en);
    step(1'b0, 1'b0, 1'b0, w_en, addr, data);
  endtask

  task automatic rd_op(input logic [31:0] addr);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, addr, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data_model", DM_rd_data, exp_rd);
      check("oob_err_model", {31'h0, dm_oob_err}, {31'h0, exp_err});
`ifdef DM_STATS_EN
      check("rd_cnt_model", dm_rd_cnt, sat(m_rd_cnt));
      check("wr_cnt_model", dm_wr_cnt, sat(m_wr_cnt));
      check("byp_cnt_model", dm_byp_cnt, sat(m_byp_cnt));
`endif
    end
  end

  initial begin
    exp_rd = '0; exp_err = 1'b0; last_wr = 0; last_idx = 0; last_old = '0;
    m_rd_cnt = 0; m_wr_cnt = 0; m_byp_cnt = 0;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;

    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    chk_en = 1'b1;
    check("reset_rd_data", DM_rd_data, 32'h0);
    check("reset_oob_err", {31'h0, dm_oob_err}, 32'h0);

    // Give every word a known value so the model and array start identical.
    for (int k = 0; k < DEPTH; k++) wr_op(32'(k * 4), 32'h0, 32'h0);
    idle();

    // 1: plain write, idle, read
    wr_op(32'h40, 32'hDEAD_BEEF, 32'h0);
    idle();
    rd_op(32'h40);
    check("t1_read", DM_rd_data, 32'hDEAD_BEEF);

    // 2: read immediately after write uses the bypass
    wr_op(32'h80, 32'h1122_3344, 32'h0);
    rd_op(32'h80);
    check("t2_bypass", DM_rd_data, 32'h1122_3344);
`ifdef DM_STATS_EN
    check("t2_byp_cnt", dm_byp_cnt, 32'd1);
`endif

    // 3: partial write, read in next cycle and later
    wr_op(32'h10, 32'hAAAA_AAAA, 32'h0);
    idle();
    wr_op(32'h10, 32'h5555_5555, 32'hFFFF_0000);
    rd_op(32'h10);
    check("t3_merge_bypass", DM_rd_data, 32'hAAAA_5555);
    idle();
    rd_op(32'h10);
    check("t3_merge_array", DM_rd_data, 32'hAAAA_5555);

    // 4: back-to-back partial writes to one word
    wr_op(32'h20, 32'h0000_00FF, 32'hFFFF_FF00);
    wr_op(32'h20, 32'h0000_AB00, 32'hFFFF_00FF);
    rd_op(32'h20);
    check("t4_b2b", DM_rd_data, 32'h0000_ABFF);

    // 5: out-of-range read, then in-range read
    check("t5_err_before", {31'h0, dm_oob_err}, 32'h0);
    rd_op(LIMIT);
    check("t5_oob_data", DM_rd_data, 32'h0);
    check("t5_oob_err", {31'h0, dm_oob_err}, 32'h1);
    rd_op(32'h40);
    check("t5_after_oob", DM_rd_data, 32'hDEAD_BEEF);
    check("t5_err_sticky", {31'h0, dm_oob_err}, 32'h1);

    // 6: reset discards the pending write
    wr_op(32'h30, 32'h1234_5678, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("t6_rst_rd_data", DM_rd_data, 32'h0);
    check("t6_rst_err", {31'h0, dm_oob_err}, 32'h0);
    rd_op(32'h30);
    check("t6_discarded", DM_rd_data, 32'h0);

    // Randomized traffic concentrated on a few words to exercise the bypass.
    for (int n = 0; n < 4000; n++) begin
      logic        r, c_en, r_en;
      logic [31:0] w_en, addr, wdata;
      r     = ($urandom_range(0, 59) == 0);
      c_en  = ($urandom_range(0, 4) == 0);
      r_en  = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       w_en = 32'h0;
        1:       w_en = 32'hFFFF_FFFF;
        default: w_en = $urandom;
      endcase
      case ($urandom_range(0, 11))
        0:       addr = LIMIT + 32'($urandom_range(0, 100000));
        1:       addr = 32'($urandom_range(0, DEPTH * 4 - 1));
        default: addr = 32'($urandom_range(0, 31));
      endcase
      step(r, c_en, r_en, w_en, addr, wdata);
    end

    idle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
